// File: rtl/alu_seq_pkg.sv
// Shared opcode map, FSM states and iterative-unit operation codes for alu_seq.
// DIV/REM are only decoded when ALU_SEQ_DIV_EN is defined.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_JUMP = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_REM  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    IT_MUL,
    IT_SLL,
    IT_SRL,
    IT_DIV,
    IT_REM
  } iter_op_e;

endpackage

// File: rtl/alu_seq_iter.sv
// One-bit-per-cycle engine for MUL/SLL/SRL (and DIV/REM with ALU_SEQ_DIV_EN).
// result is the value after the step taken this cycle; last flags the final step.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  iter_op_e                     op,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic [$clog2(WIDTH+1)-1:0]   cnt_init,
  output logic                         last,
  output logic [WIDTH-1:0]             result
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  // acc: product / shifted value / partial remainder; opd: multiplier / quotient;
  // aux: multiplicand / divisor
  logic [WIDTH-1:0] acc_q, acc_d, opd_q, opd_d, aux_q, aux_d;
  logic [WIDTH-1:0] step_acc, step_opd, step_aux;
  logic [CW-1:0]    cnt_q, cnt_d;
  iter_op_e         op_q, op_d;
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   rem_ext, rem_diff;
`endif

  always_comb begin
    step_acc = acc_q;
    step_opd = opd_q;
    step_aux = aux_q;
`ifdef ALU_SEQ_DIV_EN
    rem_ext  = {acc_q, opd_q[WIDTH-1]};
    rem_diff = rem_ext - {1'b0, aux_q};
`endif
    case (op_q)
      IT_MUL: begin
        if (opd_q[0]) step_acc = acc_q + aux_q;
        step_aux = aux_q << 1;
        step_opd = opd_q >> 1;
      end
      IT_SLL: step_acc = acc_q << 1;
      IT_SRL: step_acc = acc_q >> 1;
`ifdef ALU_SEQ_DIV_EN
      IT_DIV, IT_REM: begin
        // Restoring step: a clear top bit of the difference means the divisor fits
        if (!rem_diff[WIDTH]) begin
          step_acc = rem_diff[WIDTH-1:0];
          step_opd = {opd_q[WIDTH-2:0], 1'b1};
        end else begin
          step_acc = rem_ext[WIDTH-1:0];
          step_opd = {opd_q[WIDTH-2:0], 1'b0};
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    opd_d = opd_q;
    aux_d = aux_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    if (start) begin
      op_d  = op;
      cnt_d = cnt_init;
      acc_d = (op == IT_SLL || op == IT_SRL) ? a : '0;
      opd_d = (op == IT_MUL) ? b : a;
      aux_d = (op == IT_MUL) ? a : b;
    end else if (cnt_q != '0) begin
      acc_d = step_acc;
      opd_d = step_opd;
      aux_d = step_aux;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      opd_q <= '0;
      aux_q <= '0;
      cnt_q <= '0;
      op_q  <= IT_MUL;
    end else begin
      acc_q <= acc_d;
      opd_q <= opd_d;
      aux_q <= aux_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
    end
  end

  assign last = (cnt_q == CW'(1));
`ifdef ALU_SEQ_DIV_EN
  assign result = (op_q == IT_DIV) ? step_opd : step_acc;
`else
  assign result = step_acc;
`endif

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU with valid/ready handshake, carry/overflow flags.
// Define ALU_SEQ_DIV_EN to build the unsigned DIV/REM opcodes.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d, ovf_q, ovf_d;

  logic             iter_start, iter_last;
  iter_op_e         iter_op;
  logic [CW-1:0]    iter_cnt;
  logic [WIDTH-1:0] iter_result;

  logic [WIDTH:0]   sum, diff;
  logic [SW-1:0]    shamt;

  assign sum   = {1'b0, data1} + {1'b0, data2};
  assign diff  = {1'b0, data1} - {1'b0, data2};
  assign shamt = data2[SW-1:0];

  alu_seq_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .start    (iter_start),
    .op       (iter_op),
    .a        (data1),
    .b        (data2),
    .cnt_init (iter_cnt),
    .last     (iter_last),
    .result   (iter_result)
  );

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    iter_start = 1'b0;
    iter_op    = IT_MUL;
    iter_cnt   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d  = ST_DONE;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          result_d = '0;
          case (ALU_control)
            OP_AND: result_d = data1 & data2;
            OP_OR:  result_d = data1 | data2;
            OP_XOR: result_d = data1 ^ data2;
            OP_NOT: result_d = ~data1;
            OP_ADD: begin
              result_d = sum[WIDTH-1:0];
              carry_d  = sum[WIDTH];
              ovf_d    = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                         (sum[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_SUB: begin
              result_d = diff[WIDTH-1:0];
              carry_d  = diff[WIDTH];
              ovf_d    = (data1[WIDTH-1] != data2[WIDTH-1]) &&
                         (diff[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_MUL: begin
              state_d    = ST_EXEC;
              iter_start = 1'b1;
              iter_op    = IT_MUL;
              iter_cnt   = CW'(WIDTH);
            end
            OP_SLL, OP_SRL: begin
              if (shamt == '0) begin
                result_d = data1;
              end else begin
                state_d    = ST_EXEC;
                iter_start = 1'b1;
                iter_op    = (ALU_control == OP_SLL) ? IT_SLL : IT_SRL;
                iter_cnt   = CW'(shamt);
              end
            end
`ifdef ALU_SEQ_DIV_EN
            OP_DIV, OP_REM: begin
              if (data2 == '0) begin
                result_d = (ALU_control == OP_DIV) ? '1 : data1;
              end else begin
                state_d    = ST_EXEC;
                iter_start = 1'b1;
                iter_op    = (ALU_control == OP_DIV) ? IT_DIV : IT_REM;
                iter_cnt   = CW'(WIDTH);
              end
            end
`endif
            default: ; // JUMP and undefined opcodes give 0
          endcase
        end
      end
      ST_EXEC: begin
        if (iter_last) begin
          state_d  = ST_DONE;
          result_d = iter_result;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign ALU_result = result_q;
  assign zero       = (result_q == '0);
  assign carry      = carry_q;
  assign overflow   = ovf_q;

endmodule
